// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back stage: 15-entry register file with combinational
// source/destination selection and a single clocked commit per instruction cycle.
module decode_writeback #(
   parameter int unsigned    WIDTH  = 64,
   parameter int unsigned    NREG   = 15,
   parameter logic [3:0]     RSP_ID = 4'd4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [3:0]       i_icode,
   input  logic [3:0]       i_ra,
   input  logic [3:0]       i_rb,
   input  logic             i_cnd,
   input  logic [WIDTH-1:0] i_val_e,
   input  logic [WIDTH-1:0] i_val_m,
   input  logic             i_wb_en,
   output logic [WIDTH-1:0] o_val_a,
   output logic [WIDTH-1:0] o_val_b,
   output logic [3:0]       o_src_a,
   output logic [3:0]       o_src_b,
   output logic [3:0]       o_dst_e,
   output logic [3:0]       o_dst_m
);

   localparam logic [3:0] RNONE = 4'hF;

   logic [WIDTH-1:0] r_regs [NREG];
   logic [3:0]       w_src_a;
   logic [3:0]       w_src_b;
   logic [3:0]       w_dst_e;
   logic [3:0]       w_dst_m;

   always_comb begin
      w_src_a = RNONE;
      w_src_b = RNONE;
      w_dst_e = RNONE;
      w_dst_m = RNONE;
      case (i_icode)
         4'h2: begin
            w_src_a = i_ra;
            w_dst_e = i_cnd ? i_rb : RNONE;
         end
         4'h3: w_dst_e = i_rb;
         4'h4: begin
            w_src_a = i_ra;
            w_src_b = i_rb;
         end
         4'h5: begin
            w_src_b = i_rb;
            w_dst_m = i_ra;
         end
         4'h6: begin
            w_src_a = i_ra;
            w_src_b = i_rb;
            w_dst_e = i_rb;
         end
         4'h8: begin
            w_src_b = RSP_ID;
            w_dst_e = RSP_ID;
         end
         4'h9: begin
            w_src_a = RSP_ID;
            w_src_b = RSP_ID;
            w_dst_e = RSP_ID;
         end
         4'hA: begin
            w_src_a = i_ra;
            w_src_b = RSP_ID;
            w_dst_e = RSP_ID;
         end
         4'hB: begin
            w_src_a = RSP_ID;
            w_src_b = RSP_ID;
            w_dst_e = RSP_ID;
            w_dst_m = i_ra;
         end
         default: ;
      endcase
   end

   // Reads see only committed state; a write this cycle shows up after the edge.
   always_comb begin
      o_val_a = '0;
      o_val_b = '0;
      if (w_src_a != RNONE) o_val_a = r_regs[w_src_a];
      if (w_src_b != RNONE) o_val_b = r_regs[w_src_b];
   end

   assign o_src_a = w_src_a;
   assign o_src_b = w_src_b;
   assign o_dst_e = w_dst_e;
   assign o_dst_m = w_dst_m;

   // M port is written last so it wins when both target the same register (popq %rsp).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (i_wb_en) begin
         if (w_dst_e != RNONE) r_regs[w_dst_e] <= i_val_e;
         if (w_dst_m != RNONE) r_regs[w_dst_m] <= i_val_m;
      end
   end

endmodule
